mips_mult_div: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It sits directly downstream of the register file and consumes `read_data_1`/`read_data_2` as operands for `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo`. It feeds HI/LO back to the register file's `write_data` path for `mfhi`/`mflo`. While an operation is in flight it raises `busy`, and the control unit stalls the PC on that signal.

---
 rtl/mips_mult_div.sv | 207 ++++++++++++++++++++
 tb/tb_mips_mult_div.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mult_div.sv
// ---------------------------------------------------------------------------
// mips_mult_div
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   mult/multu use a 32-step shift-add; div/divu use a 32-step restoring
//   shift-subtract. Signed operations work on magnitudes and fix the signs in
//   a final FIX cycle. mthi/mtlo write HI/LO directly in a single edge.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   operand_a    rs value: multiplicand / dividend / mthi-mtlo source
//   operand_b    rt value: multiplier / divisor
//   op           000 none, 001 mult, 010 multu, 011 div, 100 divu,
//                101 mthi, 110 mtlo, 111 reserved (none)
//   start        qualifies op; only sampled while busy is low
//   hi_lo_sel    1 selects HI onto result, 0 selects LO
//   result       combinational HI/LO read port (mfhi/mflo)
//   busy         high while a mult/div is in RUN or FIX
//   done         one-cycle pulse after a mult/div completes
//   div_by_zero  one-cycle pulse with done when a divide had divisor 0
// ---------------------------------------------------------------------------
module mips_mult_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [2:0]  op,
    input  logic        start,
    input  logic        hi_lo_sel,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic signed [31:0] v,
                                              input logic is_signed);
        logic signed [31:0] neg_v;
        neg_v = -v;
        return (is_signed && (v < 0)) ? 32'(neg_v) : 32'(v);
    endfunction

    function automatic logic [31:0] negate32(input logic signed [31:0] v);
        logic signed [31:0] neg_v;
        neg_v = -v;
        return 32'(neg_v);
    endfunction

    function automatic logic [63:0] negate64(input logic signed [63:0] v);
        logic signed [63:0] neg_v;
        neg_v = -v;
        return 64'(neg_v);
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {remainder, dividend bits shifting into quotient}.
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;          // multiplicand or divisor magnitude
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;          // product / quotient must be negated
    logic        rem_neg_q, rem_neg_d;  // remainder takes dividend's sign
    logic        zero_div_q, zero_div_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        op_signed;
    logic        op_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shrem;
    logic        div_ge;
    logic [31:0] div_sub;

    always_comb begin
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_div    = (op == OP_DIV)  || (op == OP_DIVU);
        mag_a     = magnitude(operand_a, op_signed);
        mag_b     = magnitude(operand_b, op_signed);

        // One shift-add step: add multiplicand to the upper half when the
        // current multiplier LSB is set, then shift everything right.
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};

        // One restoring step: shift the next dividend bit into the remainder
        // and subtract the divisor if it fits. When it fits, the true
        // difference is below the divisor, so 32 bits hold it exactly.
        div_shrem = acc_q[63:31];
        div_ge    = div_shrem >= {1'b0, opb_q};
        div_sub   = div_shrem[31:0] - opb_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        zero_div_d = zero_div_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d    = S_RUN;
                            cnt_d      = 5'd0;
                            is_div_d   = op_div;
                            acc_d      = {32'd0, (op_div ? mag_a : mag_b)};
                            opb_d      = op_div ? mag_b : mag_a;
                            neg_d      = op_signed & (operand_a[31] ^ operand_b[31]);
                            rem_neg_d  = op_signed & operand_a[31];
                            zero_div_d = op_div & (operand_b == 32'd0);
                        end
                        OP_MTHI: hi_d = operand_a;
                        OP_MTLO: lo_d = operand_a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    acc_d = {(div_ge ? div_sub : div_shrem[31:0]), acc_q[30:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                dbz_d   = zero_div_q;
                if (!is_div_q) begin
                    {hi_d, lo_d} = neg_q ? negate64(acc_q) : acc_q;
                end else if (!zero_div_q) begin
                    lo_d = neg_q     ? negate32(acc_q[31:0])  : acc_q[31:0];
                    hi_d = rem_neg_q ? negate32(acc_q[63:32]) : acc_q[63:32];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            acc_q      <= 64'd0;
            opb_q      <= 32'd0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            zero_div_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            zero_div_q <= zero_div_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    // busy comes from registered state only, so the PC stall has no
    // combinational path back into start.
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign result      = hi_lo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mips_mult_div.sv
// ---------------------------------------------------------------------------
// tb_mips_mult_div
//   Directed-vector bench for mips_mult_div with hand-computed HI/LO values,
//   busy-length and done/div_by_zero pulse checks, ignored start during busy,
//   and asynchronous reset in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_mips_mult_div;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk;
    logic        rst_n;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [2:0]  op;
    logic        start;
    logic        hi_lo_sel;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_chk  = 0;
    int n_pass = 0;

    int   bcyc;
    logic dn_seen;
    logic dz_seen;

    mips_mult_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .op          (op),
        .start       (start),
        .hi_lo_sel   (hi_lo_sel),
        .result      (result),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        hi_lo_sel = 1'b1;
        #1;
        chk({tag, "_hi"}, result, exp_hi);
        hi_lo_sel = 1'b0;
        #1;
        chk({tag, "_lo"}, result, exp_lo);
    endtask

    // Issue a mult/div, scramble operands after acceptance, and follow busy
    // until it drops. On busy cycle number inj a start with iop/ia is pulsed.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj, input logic [2:0] iop, input logic [31:0] ia);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        op        = OP_NONE;
        operand_a = $urandom;
        operand_b = $urandom;
        bcyc      = 0;
        while (busy && bcyc < 100) begin
            bcyc++;
            if (bcyc == inj) begin
                start     = 1'b1;
                op        = iop;
                operand_a = ia;
            end else begin
                start = 1'b0;
                op    = OP_NONE;
            end
            @(posedge clk); #1;
        end
        start   = 1'b0;
        op      = OP_NONE;
        dn_seen = done;
        dz_seen = div_by_zero;
    endtask

    task automatic chk_pulse_end(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_off"}, 32'(done), 32'd0);
    endtask

    task automatic do_mt(input logic [2:0] o, input logic [31:0] a);
        op        = o;
        operand_a = a;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        op        = OP_NONE;
        operand_a = 32'hDEAD_BEEF;
    endtask

    initial begin
        rst_n     = 1'b0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        op        = OP_NONE;
        start     = 1'b0;
        hi_lo_sel = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        chk_hilo("rst", 32'd0, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // mult 7 * -3 = -21
        do_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, -1, OP_NONE, 32'd0);
        chk("mult_busy_cycles", 32'(bcyc), 32'd33);
        chk("mult_done", 32'(dn_seen), 32'd1);
        chk("mult_dbz", 32'(dz_seen), 32'd0);
        chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        chk_pulse_end("mult");

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, OP_NONE, 32'd0);
        chk("multu_done", 32'(dn_seen), 32'd1);
        chk_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, -1, OP_NONE, 32'd0);
        chk_hilo("mult_minmin", 32'h4000_0000, 32'h0000_0000);

        // div -7 / 2 = -3 rem -1
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, OP_NONE, 32'd0);
        chk("div_busy_cycles", 32'(bcyc), 32'd33);
        chk("div_done", 32'(dn_seen), 32'd1);
        chk("div_dbz", 32'(dz_seen), 32'd0);
        chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, OP_NONE, 32'd0);
        chk_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);

        do_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, -1, OP_NONE, 32'd0);
        chk_hilo("divu", 32'h0000_0001, 32'h7FFF_FFFC);

        // mthi / mtlo then divide by zero leaves HI/LO intact
        do_mt(OP_MTHI, 32'h0000_1234);
        hi_lo_sel = 1'b1;
        #1;
        chk("mthi", result, 32'h0000_1234);
        chk("mthi_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        do_mt(OP_MTLO, 32'h0000_5678);
        hi_lo_sel = 1'b0;
        #1;
        chk("mtlo", result, 32'h0000_5678);
        @(posedge clk); #1;

        do_op(OP_DIV, 32'd5, 32'd0, -1, OP_NONE, 32'd0);
        chk("dbz_busy_cycles", 32'(bcyc), 32'd33);
        chk("dbz_done", 32'(dn_seen), 32'd1);
        chk("dbz_flag", 32'(dz_seen), 32'd1);
        chk_hilo("dbz", 32'h0000_1234, 32'h0000_5678);
        @(posedge clk); #1;
        chk("dbz_flag_off", 32'(div_by_zero), 32'd0);

        // mult 3*4 with an mtlo pulsed during busy, which must be ignored
        do_op(OP_MULT, 32'd3, 32'd4, 5, OP_MTLO, 32'h0000_FFFF);
        chk("ign_busy_cycles", 32'(bcyc), 32'd33);
        chk("ign_done", 32'(dn_seen), 32'd1);
        chk_hilo("ign", 32'd0, 32'd12);

        // reset mid-operation
        op        = OP_MULT;
        operand_a = 32'd5;
        operand_b = 32'd6;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op    = OP_NONE;
        repeat (9) @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        hi_lo_sel = 1'b0;
        #1;
        chk("mid_rst_lo", result, 32'd0);
        hi_lo_sel = 1'b1;
        #1;
        chk("mid_rst_hi", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(OP_MULTU, 32'd2, 32'd3, -1, OP_NONE, 32'd0);
        chk("post_rst_busy_cycles", 32'(bcyc), 32'd33);
        chk("post_rst_done", 32'(dn_seen), 32'd1);
        chk_hilo("post_rst", 32'd0, 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
